// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - block-buffer and round-datapath handshakes of the SHA-256 message schedule
interface sha256_msg_schedule_if;
    logic        in_valid;
    logic [31:0] in_word;
    logic        in_ready;
    logic        w_valid;
    logic [31:0] w_out;
    logic [5:0]  w_index;
    logic        w_ready;
    logic        block_done;

    modport master (
        input  in_valid, in_word, w_ready,
        output in_ready, w_valid, w_out, w_index, block_done
    );

    modport slave (
        output in_valid, in_word, w_ready,
        input  in_ready, w_valid, w_out, w_index, block_done
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule, W0..W63 from a 16-word sliding window
// Optional: SHA_SCHED_BYTESWAP_EN byte-reverses each incoming word before use.
module sha256_msg_schedule (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         abort,
    sha256_msg_schedule_if.master        sched
);

    typedef enum logic [1:0] {LOAD, EXPAND, DRAIN} stateT;

    stateT       state;
    logic [5:0]  cnt;
    logic [31:0] win [16];
    logic        wValid;
    logic [31:0] wOut;
    logic [5:0]  wIndex;

    logic        slotFree;
    logic [31:0] inWord;
    logic [31:0] newWord;
    logic [31:0] pushWord;
    logic        pushEn;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

`ifdef SHA_SCHED_BYTESWAP_EN
    assign inWord = {sched.in_word[7:0], sched.in_word[15:8],
                     sched.in_word[23:16], sched.in_word[31:24]};
`else
    assign inWord = sched.in_word;
`endif

    // Taps are W[t-2], W[t-7], W[t-15], W[t-16] with win[15] holding W[t-1]
    assign newWord  = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    assign slotFree = !wValid || sched.w_ready;
    assign pushEn   = ((state == LOAD) && sched.in_valid && slotFree) ||
                      ((state == EXPAND) && slotFree);
    assign pushWord = (state == LOAD) ? inWord : newWord;

    assign sched.in_ready   = (state == LOAD) && slotFree;
    assign sched.w_valid    = wValid;
    assign sched.w_out      = wOut;
    assign sched.w_index    = wIndex;
    // Pulses in the same cycle W63 is consumed so the next block can load right after
    assign sched.block_done = (state == DRAIN) && wValid && sched.w_ready && !abort;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= LOAD;
            cnt    <= '0;
            wValid <= 1'b0;
            wOut   <= '0;
            wIndex <= '0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (abort) begin
            state  <= LOAD;
            cnt    <= '0;
            wValid <= 1'b0;
        end else begin
            if (pushEn) begin
                wOut   <= pushWord;
                wIndex <= cnt;
                wValid <= 1'b1;
                cnt    <= cnt + 6'd1;
                for (int i = 0; i < 15; i++) begin
                    win[i] <= win[i+1];
                end
                win[15] <= pushWord;
            end else if (sched.w_ready) begin
                wValid <= 1'b0;
            end

            case (state)
                LOAD: begin
                    if (pushEn && cnt == 6'd15) begin
                        state <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (pushEn && cnt == 6'd63) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wValid && sched.w_ready) begin
                        cnt   <= '0;
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - directed self-checking bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

    logic clock = 1'b0;
    logic resetn;
    logic abort;

    sha256_msg_schedule_if bus ();

    sha256_msg_schedule dut (
        .clock  (clock),
        .resetn (resetn),
        .abort  (abort),
        .sched  (bus.master)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] msg  [16];
    logic [31:0] expW [64];
    logic [31:0] obsW [64];
    logic [31:0] msgNext0;

    logic        sWv;
    logic [31:0] sWout;
    logic [5:0]  sIdx;
    logic        sInReady;
    logic        sDone;

    function automatic logic [31:0] feed(input logic [31:0] x);
`ifdef SHA_SCHED_BYTESWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic compute_model();
        for (int t = 0; t < 16; t++) expW[t] = msg[t];
        for (int t = 16; t < 64; t++)
            expW[t] = s1(expW[t-2]) + expW[t-7] + s0(expW[t-15]) + expW[t-16];
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        compute_model();
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
        compute_model();
    endtask

    task automatic do_cycle(input logic iv, input logic [31:0] iw, input logic wr, input logic ab);
        @(negedge clock);
        bus.in_valid = iv;
        bus.in_word  = iw;
        bus.w_ready  = wr;
        abort        = ab;
        #1;
        sWv      = bus.w_valid;
        sWout    = bus.w_out;
        sIdx     = bus.w_index;
        sInReady = bus.in_ready;
        sDone    = bus.block_done;
    endtask

    // Streams msg through the stage, checking every output cycle against the model
    task automatic run_block(input string name, input bit stall, input bit b2b,
                             output int doneCyc, output int firstAcc);
        int          inPtr = 0;
        int          expIdx = 0;
        int          c = 0;
        bit          pStall = 0;
        bit          done = 0;
        logic [31:0] pOut = '0;
        logic [5:0]  pIdx = '0;
        logic        iv, wr, expDone, expReady;
        logic [31:0] iw;
        doneCyc  = -1;
        firstAcc = -1;
        for (int i = 0; i < 64; i++) obsW[i] = 32'hDEADBEEF;
        while (!done && c < 400) begin
            iv = (inPtr < 16) ? (stall ? ($urandom_range(0, 3) != 0) : 1'b1) : b2b;
            iw = (inPtr < 16) ? feed(msg[inPtr]) : feed(msgNext0);
            wr = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            do_cycle(iv, iw, wr, 1'b0);
            if (pStall) begin
                checks++;
                if (sWv !== 1'b1 || sWout !== pOut || sIdx !== pIdx) begin
                    errors++;
                    $display("FAIL %s stall_hold c=%0d: got v=%b w=%h i=%0d, want v=1 w=%h i=%0d",
                             name, c, sWv, sWout, sIdx, pOut, pIdx);
                end
            end
            expReady = (inPtr < 16) && (!sWv || wr);
            checks++;
            if (sInReady !== expReady) begin
                errors++;
                $display("FAIL %s in_ready c=%0d: got %b, want %b", name, c, sInReady, expReady);
            end
            if (iv && sInReady && inPtr < 16) begin
                if (firstAcc < 0) firstAcc = c;
                inPtr++;
            end
            expDone = sWv && wr && (expIdx == 63);
            checks++;
            if (sDone !== expDone) begin
                errors++;
                $display("FAIL %s block_done c=%0d: got %b, want %b", name, c, sDone, expDone);
            end
            if (sWv && wr) begin
                checks++;
                if (sIdx !== 6'(expIdx)) begin
                    errors++;
                    $display("FAIL %s w_index: got %0d, want %0d", name, sIdx, expIdx);
                end
                checks++;
                if (sWout !== expW[expIdx]) begin
                    errors++;
                    $display("FAIL %s w_out[%0d]: got %h, want %h", name, expIdx, sWout, expW[expIdx]);
                end
                obsW[expIdx] = sWout;
                if (expIdx == 63) begin
                    done    = 1;
                    doneCyc = c;
                end
                expIdx++;
            end
            pStall = sWv && !wr;
            pOut   = sWout;
            pIdx   = sIdx;
            c++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: got %0d words, want 64", name, expIdx);
        end
    endtask

    // Feeds the current msg with w_ready high until W[idx] is presented
    task automatic advance_to(input int idx, output bit hit);
        int inPtr = 0;
        int c = 0;
        hit = 0;
        while (!hit && c < 100) begin
            do_cycle(inPtr < 16, feed(msg[inPtr < 16 ? inPtr : 0]), 1'b1, 1'b0);
            if (sInReady && inPtr < 16) inPtr++;
            if (sWv && sIdx == 6'(idx)) hit = 1;
            c++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.w_valid !== 1'b0 || bus.w_out !== 32'h0 || bus.w_index !== 6'd0 ||
            bus.block_done !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got v=%b w=%h i=%0d d=%b r=%b, want v=0 w=0 i=0 d=0 r=1",
                     bus.w_valid, bus.w_out, bus.w_index, bus.block_done, bus.in_ready);
        end
    endtask

    task automatic test_abc();
        logic [31:0] hand [18];
        int d, fa;
        for (int i = 0; i < 18; i++) hand[i] = 32'h0;
        hand[0]  = 32'h61626380;
        hand[15] = 32'h00000018;
        hand[16] = 32'h61626380;
        hand[17] = 32'h000F0000;
        set_abc();
        run_block("abc", 1'b0, 1'b0, d, fa);
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (obsW[i] !== hand[i]) begin
                errors++;
                $display("FAIL abc_hand W%0d: got %h, want %h", i, obsW[i], hand[i]);
            end
        end
        checks++;
        if (fa !== 0 || d !== 64) begin
            errors++;
            $display("FAIL abc_latency: got accept=%0d done=%0d, want accept=0 done=64", fa, d);
        end
    endtask

    task automatic test_random_stall();
        int d, fa;
        for (int k = 0; k < 3; k++) begin
            set_random();
            run_block("random_stall", 1'b1, 1'b0, d, fa);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] second [16];
        int d, fa;
        for (int i = 0; i < 16; i++) second[i] = $urandom;
        set_random();
        msgNext0 = second[0];
        run_block("b2b_first", 1'b0, 1'b1, d, fa);
        for (int i = 0; i < 16; i++) msg[i] = second[i];
        compute_model();
        run_block("b2b_second", 1'b0, 1'b0, d, fa);
        checks++;
        if (fa !== 0 || d !== 64) begin
            errors++;
            $display("FAIL b2b_timing: got accept=%0d done=%0d, want accept=0 done=64", fa, d);
        end
    endtask

    task automatic test_abort();
        bit hit;
        int d, fa;
        set_random();
        advance_to(63, hit);
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach63: got no W63, want W63");
        end
        abort = 1'b1;
        #1;
        checks++;
        if (bus.block_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_drain_done: got %b, want 0", bus.block_done);
        end
        do_cycle(1'b1, feed(32'h12345678), 1'b1, 1'b1);
        do_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (sWv !== 1'b0 || sInReady !== 1'b1) begin
            errors++;
            $display("FAIL abort_beats_input: got v=%b r=%b, want v=0 r=1", sWv, sInReady);
        end
        set_random();
        advance_to(29, hit);
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach29: got no W29, want W29");
        end
        abort = 1'b1;
        do_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (sWv !== 1'b0 || sInReady !== 1'b1 || sDone !== 1'b0) begin
            errors++;
            $display("FAIL abort_expand: got v=%b r=%b d=%b, want v=0 r=1 d=0", sWv, sInReady, sDone);
        end
        set_random();
        run_block("after_abort", 1'b1, 1'b0, d, fa);
    endtask

    task automatic test_async_reset();
        int inPtr = 0;
        int c = 0;
        int d, fa;
        set_abc();
        while (inPtr < 7 && c < 50) begin
            do_cycle(1'b1, feed(msg[inPtr]), 1'b1, 1'b0);
            if (sInReady) inPtr++;
            c++;
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.w_valid !== 1'b1 || bus.w_index !== 6'd6) begin
            errors++;
            $display("FAIL pre_reset_cnt7: got v=%b i=%0d, want v=1 i=6", bus.w_valid, bus.w_index);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.w_valid !== 1'b0 || bus.w_out !== 32'h0 || bus.w_index !== 6'd0 ||
            bus.block_done !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got v=%b w=%h i=%0d d=%b r=%b, want v=0 w=0 i=0 d=0 r=1",
                     bus.w_valid, bus.w_out, bus.w_index, bus.block_done, bus.in_ready);
        end
        @(negedge clock);
        resetn = 1'b1;
        run_block("after_reset", 1'b0, 1'b0, d, fa);
        checks++;
        if (d !== 64) begin
            errors++;
            $display("FAIL after_reset_done: got %0d, want 64", d);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_word  = 32'h0;
        bus.w_ready  = 1'b0;
        msgNext0     = 32'h0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        test_reset();
        test_abc();
        test_random_stall();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
